quant_drain_ctrl: RTL

Drain controller that shares the single `Quantizer` datapath among `NUM_REQ` accumulator columns of the systolic array. After a `start` pulse it pulls exactly `cfg_count` accumulator words from every column in round-robin order and requantizes each word to `DATA_WIDTH`. Each result is tagged with its column index and queued in a 2-entry output buffer toward the activation writeback. It pulses `done` when every column is drained and the buffer is empty.

---
 rtl/npu_pkg.sv | 16 +
 rtl/quant_drain_ctrl_if.sv | 34 +++
 rtl/Quantizer.sv | 26 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/quant_drain_ctrl.sv | 131 +++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// Shared NPU types: accumulator/activation word formats and the drain FSM encoding.
// ACC_WIDTH/DATA_WIDTH carry the same values as the global width header.
package npu_pkg;
  localparam int ACC_WIDTH   = 32;
  localparam int DATA_WIDTH  = 8;
  localparam int QUANT_SHIFT = 8;

  typedef logic signed [ACC_WIDTH-1:0]  acc_t;
  typedef logic signed [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } drain_state_e;
endpackage

// File: rtl/quant_drain_ctrl_if.sv
// Bundle between the drain controller, the accumulator columns and the activation writeback.
interface quant_drain_ctrl_if
  import npu_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 16
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic                 start;
  logic [CNT_WIDTH-1:0] cfg_count;
  logic                 busy;
  logic                 done;
  // Handshake: a word moves on a rising edge where valid and ready are both high;
  // ready may depend combinationally on valid, valid never waits on ready.
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  acc_t                 req_data [NUM_REQ];
  logic                 out_valid;
  logic                 out_ready;
  data_t                out_data;
  logic [ID_W-1:0]      out_id;
  drain_state_e         state_dbg;

  modport master (
    output start, cfg_count, req_valid, req_data, out_ready,
    input  busy, done, req_ready, out_valid, out_data, out_id, state_dbg
  );

  modport slave (
    input  start, cfg_count, req_valid, req_data, out_ready,
    output busy, done, req_ready, out_valid, out_data, out_id, state_dbg
  );
endinterface

// File: rtl/Quantizer.sv
// Requantizer: round-half-up arithmetic shift by QUANT_SHIFT, saturated to DATA_WIDTH.
module Quantizer
  import npu_pkg::*;
(
  input  acc_t  acc_i,
  output data_t data_o
);
  localparam logic signed [ACC_WIDTH:0] ROUND   = (ACC_WIDTH+1)'(2 ** (QUANT_SHIFT - 1));
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_WIDTH:0] biased;
  logic signed [ACC_WIDTH:0] shifted;

  always_comb begin
    biased  = $signed({acc_i[ACC_WIDTH-1], acc_i}) + ROUND;
    shifted = biased >>> QUANT_SHIFT;
    if (shifted > SAT_MAX) begin
      data_o = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      data_o = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      data_o = shifted[DATA_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            gnt_valid_o
);
  logic [ID_W:0] idx;

  always_comb begin
    gnt_o       = '0;
    gnt_id_o    = '0;
    gnt_valid_o = 1'b0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N)) idx = idx - (ID_W+1)'(N);
      if (!gnt_valid_o && req_i[idx[ID_W-1:0]]) begin
        gnt_valid_o              = 1'b1;
        gnt_id_o                 = idx[ID_W-1:0];
        gnt_o[idx[ID_W-1:0]]     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/quant_drain_ctrl.sv
// Drains cfg_count words from each accumulator column round-robin through one shared
// Quantizer into a 2-entry tagged output FIFO; pulses done once all columns are empty.
module quant_drain_ctrl
  import npu_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  quant_drain_ctrl_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  typedef logic [ID_W-1:0]      req_id_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  drain_state_e state_q, state_d;
  cnt_t         rem_q [NUM_REQ];
  cnt_t         rem_d [NUM_REQ];
  req_id_t      ptr_q, ptr_d;
  data_t        buf_data_q [2];
  data_t        buf_data_d [2];
  req_id_t      buf_id_q [2];
  req_id_t      buf_id_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   occ_q, occ_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  req_id_t            gnt_id;
  logic               gnt_valid;
  acc_t               q_in;
  data_t              q_out;
  logic               pop;
  logic               all_zero_next;

  // A full buffer blocks every grant, even in a cycle where the head is popped.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = (state_q == DRAIN) && bus.req_valid[i] && (rem_q[i] != '0) && (occ_q != 2'd2);
    end
  end

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i       (elig),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .gnt_valid_o (gnt_valid)
  );

  assign q_in = bus.req_data[gnt_id];

  Quantizer u_quant (
    .acc_i  (q_in),
    .data_o (q_out)
  );

  assign pop = (occ_q != 2'd0) && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    ptr_d      = ptr_q;
    buf_data_d = buf_data_q;
    buf_id_d   = buf_id_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q + 2'(gnt_valid) - 2'(pop);

    if (gnt_valid) begin
      buf_data_d[wr_ptr_q] = q_out;
      buf_id_d[wr_ptr_q]   = gnt_id;
      wr_ptr_d             = ~wr_ptr_q;
      rem_d[gnt_id]        = rem_q[gnt_id] - cnt_t'(1);
      ptr_d                = (gnt_id == req_id_t'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    all_zero_next = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rem_d[i] != '0) all_zero_next = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < NUM_REQ; i++) rem_d[i] = bus.cfg_count;
          ptr_d   = '0;
          state_d = (bus.cfg_count == '0) ? FLUSH : DRAIN;
        end
      end
      DRAIN:   if (all_zero_next) state_d = FLUSH;
      FLUSH:   if (occ_q == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      for (int i = 0; i < NUM_REQ; i++) rem_q[i] <= '0;
      for (int j = 0; j < 2; j++) begin
        buf_data_q[j] <= '0;
        buf_id_q[j]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      rem_q      <= rem_d;
      buf_data_q <= buf_data_d;
      buf_id_q   <= buf_id_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FLUSH) && (occ_q == 2'd0);
  assign bus.req_ready = gnt;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = buf_data_q[rd_ptr_q];
  assign bus.out_id    = buf_id_q[rd_ptr_q];
  assign bus.state_dbg = state_q;
endmodule
